// File: rtl/magnitude_comparator.sv
// rtl/magnitude_comparator.sv - registered N-bit signed/unsigned magnitude comparator (optional min/max via COMPARATOR_MINMAX_EN)
module magnitude_comparator #(
    parameter int N      = 4,
    parameter int SIGNED = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    output logic         gt,
    output logic         lt,
    output logic         eq
`ifdef COMPARATOR_MINMAX_EN
    ,
    output logic [N-1:0] min,
    output logic [N-1:0] max
`endif
);

    // Flipping the sign bit maps two's complement order onto unsigned order,
    // so one unsigned compare serves both signedness modes.
    localparam logic [N-1:0] SIGN_MASK = (SIGNED != 0) ? (N'(1) << (N - 1)) : '0;

    logic [N-1:0] a_key;
    logic [N-1:0] b_key;
    logic         is_gt;
    logic         is_lt;
    logic         is_eq;

    // Relational decode straight from the unregistered operands
    always_comb begin
        a_key = a ^ SIGN_MASK;
        b_key = b ^ SIGN_MASK;
        is_eq = (a == b);
        is_gt = (a_key > b_key);
        is_lt = !is_eq && !is_gt;
    end

    // Result register: valid follows in_valid, flags hold across gaps
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            eq        <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                gt <= is_gt;
                lt <= is_lt;
                eq <= is_eq;
            end
        end
    end

`ifdef COMPARATOR_MINMAX_EN
    logic [N-1:0] lo_val;
    logic [N-1:0] hi_val;

    // Smaller/larger operand; equality falls through to a on both sides
    always_comb begin
        lo_val = is_gt ? b : a;
        hi_val = is_lt ? b : a;
    end

    // Min/max register, updated in lockstep with the flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min <= '0;
            max <= '0;
        end else if (in_valid) begin
            min <= lo_val;
            max <= hi_val;
        end
    end
`endif

endmodule

// File: tb/tb_magnitude_comparator.sv
// tb/tb_magnitude_comparator.sv - scoreboard bench for magnitude_comparator (signed/unsigned N=4, signed N=1)
module tb_magnitude_comparator;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [3:0] a_in;
    logic [3:0] b_in;

    logic s_valid, s_gt, s_lt, s_eq;
    logic u_valid, u_gt, u_lt, u_eq;
    logic o_valid, o_gt, o_lt, o_eq;
`ifdef COMPARATOR_MINMAX_EN
    logic [3:0] s_min, s_max, u_min, u_max;
    logic [0:0] o_min, o_max;
`endif

    typedef struct {
        logic [2:0] s;
        logic [2:0] u;
        logic [2:0] o;
        logic [3:0] s_min;
        logic [3:0] s_max;
        logic [3:0] u_min;
        logic [3:0] u_max;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    magnitude_comparator #(.N(4), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a_in), .b(b_in),
        .out_valid(s_valid), .gt(s_gt), .lt(s_lt), .eq(s_eq)
`ifdef COMPARATOR_MINMAX_EN
        , .min(s_min), .max(s_max)
`endif
    );

    magnitude_comparator #(.N(4), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a_in), .b(b_in),
        .out_valid(u_valid), .gt(u_gt), .lt(u_lt), .eq(u_eq)
`ifdef COMPARATOR_MINMAX_EN
        , .min(u_min), .max(u_max)
`endif
    );

    magnitude_comparator #(.N(1), .SIGNED(1)) dut_o (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a_in[0]), .b(b_in[0]),
        .out_valid(o_valid), .gt(o_gt), .lt(o_lt), .eq(o_eq)
`ifdef COMPARATOR_MINMAX_EN
        , .min(o_min), .max(o_max)
`endif
    );

    function automatic logic [2:0] rel(input int x, input int y);
        return {x > y, x < y, x == y};
    endfunction

    function automatic exp_t model(input logic [3:0] x, input logic [3:0] y);
        exp_t m;
        int sx, sy, ox, oy;
        sx = (x > 4'd7) ? int'(x) - 16 : int'(x);
        sy = (y > 4'd7) ? int'(y) - 16 : int'(y);
        ox = x[0] ? -1 : 0;
        oy = y[0] ? -1 : 0;
        m.s     = rel(sx, sy);
        m.u     = rel(int'(x), int'(y));
        m.o     = rel(ox, oy);
        m.s_min = (sy < sx) ? y : x;
        m.s_max = (sy > sx) ? y : x;
        m.u_min = (y < x) ? y : x;
        m.u_max = (y > x) ? y : x;
        return m;
    endfunction

    task automatic drive(input logic v, input logic [3:0] x, input logic [3:0] y);
        @(negedge clk);
        in_valid = v;
        a_in     = x;
        b_in     = y;
        if (v) sb.push_back(model(x, y));
    endtask

    task automatic check3(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    endtask

    // Scoreboard: every fresh result must match the oldest outstanding sample
    always @(negedge clk) begin
        if (!rst && s_valid) begin
            exp_t e;
            checks++;
            assert (sb.size() > 0) passed++;
            else $error("FAIL sb_underflow observed=%0d expected>0 a=%0d b=%0d", sb.size(), a_in, b_in);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check3("signed_flags", {1'b0, s_gt, s_lt, s_eq}, {1'b0, e.s});
                check3("unsigned_flags", {u_valid, u_gt, u_lt, u_eq}, {1'b1, e.u});
                check3("n1_flags", {o_valid, o_gt, o_lt, o_eq}, {1'b1, e.o});
`ifdef COMPARATOR_MINMAX_EN
                check3("signed_min", s_min, e.s_min);
                check3("signed_max", s_max, e.s_max);
                check3("unsigned_min", u_min, e.u_min);
                check3("unsigned_max", u_max, e.u_max);
`endif
            end
        end
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        a_in     = 4'd3;
        b_in     = 4'd3;

        // Reset state, with a valid sample presented that must be ignored
        #2;
        check3("reset_state", {s_valid, s_gt, s_lt, s_eq}, 4'b0000);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check3("idle_after_reset", {s_valid, s_gt, s_lt, s_eq, u_gt, u_lt, u_eq}, 7'b0);

        // Exhaustive sweep, one pair per cycle
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                drive(1'b1, 4'(i), 4'(j));
        drive(1'b0, 4'd0, 4'd0);

        // Valid gap: one pulse, lt held through three idle cycles
        drive(1'b1, 4'd2, 4'd5);
        drive(1'b0, 4'd0, 4'd0);
        drive(1'b0, 4'd0, 4'd0);
        check3("gap1", {s_valid, s_lt, s_gt, s_eq}, 4'b0100);
        drive(1'b0, 4'd0, 4'd0);
        check3("gap2", {s_valid, s_lt, s_gt, s_eq}, 4'b0100);
        @(negedge clk);
        check3("gap3", {s_valid, s_lt, s_gt, s_eq}, 4'b0100);

        // Back-to-back with async reset landing on the second pair
        drive(1'b1, 4'd1, 4'd1);
        drive(1'b1, 4'd6, 4'd2);
        #2;
        rst = 1'b1;
        #1;
        check3("async_reset", {s_valid, s_gt, s_lt, s_eq}, 4'b0000);
        sb.delete();
        @(negedge clk);
        check3("reset_hold", {s_valid, s_gt, s_lt, s_eq}, 4'b0000);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check3("discarded_sample", {s_valid, s_gt, s_lt, s_eq}, 4'b0000);
        drive(1'b1, 4'd0, 4'd7);
        drive(1'b1, 4'd13, 4'd2);
        drive(1'b0, 4'd0, 4'd0);

        repeat (3) @(negedge clk);
        checks++;
        assert (sb.size() == 0) passed++;
        else $error("FAIL sb_drain observed=%0d expected=0", sb.size());

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/magnitude_comparator.md
Name: magnitude_comparator

Overview:
Parameterised N-bit magnitude comparator with registered outputs. Compares operands a and b as signed (two's complement) or unsigned, selected at elaboration time. Produces one-hot greater/less/equal flags one clock after a valid input. Used wherever datapath blocks need a registered relational result; a general-purpose leaf block.

Parameters:
N, 4, operand width in bits; legal range 1..64.
SIGNED, 1, 1 = operands are two's complement; 0 = operands are unsigned.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  qualifies a and b this cycle.
a  input  N  first operand.
b  input  N  second operand.
out_valid  output  1  gt/lt/eq (and min/max, when enabled) hold a fresh result.
gt  output  1  a > b.
lt  output  1  a < b.
eq  output  1  a == b.

Behaviour:
- Reset: asynchronous assert; out_valid=0, gt=0, lt=0, eq=0 (and min=0, max=0 when enabled). Release is synchronous to clk; first capture on the first rising edge after deassertion.
- Latency: exactly 1 cycle. A sample with in_valid=1 at edge k drives out_valid=1 and the result after edge k.
- in_valid=0 at an edge: out_valid drops to 0; gt/lt/eq hold their previous values (no clear).
- No backpressure; a new sample may be accepted every cycle. Back-to-back valid inputs give back-to-back results.
- Exactly one of gt/lt/eq is 1 whenever out_valid=1. All three are 0 only after reset, before the first valid sample.
- SIGNED=1: compare as two's complement. The MSB is the sign bit; the most negative value (-2^(N-1)) is less than every other value.
- SIGNED=0: compare as plain binary magnitude.
- eq is a bitwise equality and does not depend on SIGNED.
- N=1, SIGNED=1: the value 1 represents -1, so 1 < 0.
- Reset asserted mid-stream: outputs clear at once; any in-flight sample is discarded.
- Inputs are not registered. The comparison is combinational from a/b into the output flops.

Optional Feature:
Macro COMPARATOR_MINMAX_EN.
- Defined: adds outputs min (N bits) and max (N bits), registered together with gt/lt/eq.
  - min = the smaller operand under the active signedness; max = the larger one.
  - On equality, min = max = a.
  - Both reset to 0 and hold when in_valid=0.
- Undefined: the min and max ports and their logic are absent.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with in_valid=1 -> out_valid, gt, lt, eq go to 0 immediately, without a clock edge.
- Exhaustive, N=4, SIGNED=1: sweep a,b over -8..7, one pair per cycle -> one cycle later exactly one flag is set, matching the signed relation. Examples: a=-8,b=7 -> lt=1; a=-1,b=-2 -> gt=1; a=3,b=3 -> eq=1.
- Exhaustive, N=4, SIGNED=0: same sweep, operands read unsigned -> a=4'b1000,b=4'b0111 -> gt=1; a=15,b=0 -> gt=1.
- Valid gaps: valid a=2,b=5, then in_valid=0 for 3 cycles -> out_valid pulses once; lt stays 1 through the gap.
- Back-to-back and reset mid-stream: pairs (1,1),(6,2),(0,7) on consecutive cycles -> eq, gt, lt on consecutive cycles. Assert rst during the second pair -> no result for it; flags are 0.
- COMPARATOR_MINMAX_EN with SIGNED=1: a=-3,b=2 -> min=-3, max=2. With SIGNED=0, the same bit patterns (13, 2) -> min=2, max=13.
